regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite / wr / WriteData) between two requesters.
  - Port A: core writeback.
  - Port B: the UART/IO loader or debug writer.
- Each port has a one-entry holding buffer and a valid/ready handshake.
- Fixed priority goes to A; B ages, and after MAX_WAIT lost cycles it is guaranteed the next grant.
- The write outputs are registered and drive the register file directly.

---
 rtl/regfile_write_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-port write arbiter for the register-file write port with B aging
module regfile_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              busy
);

    typedef enum logic {NORMAL, B_URGENT} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t            state, state_nxt;
    logic              full_a, full_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic [3:0]        wait_b, wait_b_nxt;
    logic              grant_a, grant_b;

    // Grants depend on registered state only, so ready never depends on valid.
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_nxt  = state;
        wait_b_nxt = wait_b;
        case (state)
            NORMAL: begin
                grant_a = full_a;
                grant_b = full_b && !full_a;
                if (wait_b == WAIT_LAST && full_b && !grant_b)
                    state_nxt = B_URGENT;
            end
            B_URGENT: begin
                grant_b = full_b;
                grant_a = full_a && !full_b;
                if (grant_b)
                    state_nxt = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase
        if (grant_b)
            wait_b_nxt = 4'd0;
        else if (full_b && wait_b != 4'hF)
            wait_b_nxt = wait_b + 4'd1;
    end

    assign a_ready = !full_a || grant_a;
    assign b_ready = !full_b || grant_b;
    assign busy    = full_a || full_b || reg_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= NORMAL;
            wait_b    <= 4'd0;
            full_a    <= 1'b0;
            full_b    <= 1'b0;
            addr_a    <= '0;
            addr_b    <= '0;
            data_a    <= '0;
            data_b    <= '0;
            reg_we    <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
        end else begin
            state  <= state_nxt;
            wait_b <= wait_b_nxt;

            // A granted buffer may be refilled on the same edge it drains.
            if (a_valid && a_ready) begin
                full_a <= 1'b1;
                addr_a <= a_addr;
                data_a <= a_data;
            end else if (grant_a) begin
                full_a <= 1'b0;
            end

            if (b_valid && b_ready) begin
                full_b <= 1'b1;
                addr_b <= b_addr;
                data_b <= b_data;
            end else if (grant_b) begin
                full_b <= 1'b0;
            end

            // Address 0 is consumed but never written.
            if (grant_a) begin
                reg_we    <= (addr_a != '0);
                reg_waddr <= addr_a;
                reg_wdata <= data_a;
            end else if (grant_b) begin
                reg_we    <= (addr_b != '0);
                reg_waddr <= addr_b;
                reg_wdata <= data_b;
            end else begin
                reg_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed and random checks of regfile_write_arbiter against an aging model
module tb_regfile_write_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              a_valid = 1'b0, b_valid = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_data = '0, b_data = '0;
    logic              a_ready, b_ready, reg_we, busy;
    logic [ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;

    regfile_write_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: each port holds at most one pending write; B tracks how many
    // grants it has lost since it last won and wins outright once that reaches MAX_WAIT.
    bit                m_known = 1'b0;
    bit                pa = 1'b0, pb = 1'b0;
    logic [ADDR_W-1:0] maa = '0, mba = '0;
    logic [DATA_W-1:0] mad = '0, mbd = '0;
    int                lost = 0;
    logic              ewe = 1'b0;
    logic [ADDR_W-1:0] ewa = '0;
    logic [DATA_W-1:0] ewd = '0;
    logic              m_rdy_a = 1'b1, m_rdy_b = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic av, input logic [ADDR_W-1:0] aa,
                        input logic [DATA_W-1:0] ad, input logic bv,
                        input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        bit wa, wb;
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        wb = pb && (!pa || lost >= MAX_WAIT);
        wa = pa && !wb;
        m_rdy_a = !pa || wa;
        m_rdy_b = !pb || wb;
        #1;
        if (m_known) begin
            chk("a_ready", a_ready, m_rdy_a);
            chk("b_ready", b_ready, m_rdy_b);
        end
        @(posedge clk);
        #1;
        if (!r) begin
            m_known = 1'b1;
            pa = 1'b0; pb = 1'b0; lost = 0;
            ewe = 1'b0; ewa = '0; ewd = '0;
        end else if (m_known) begin
            if (wa) begin
                ewe = (maa != 0); ewa = maa; ewd = mad;
            end else if (wb) begin
                ewe = (mba != 0); ewa = mba; ewd = mbd;
            end else begin
                ewe = 1'b0;
            end
            if (wb) lost = 0;
            else if (pb && lost < 15) lost++;
            if (av && m_rdy_a) begin pa = 1'b1; maa = aa; mad = ad; end
            else if (wa) pa = 1'b0;
            if (bv && m_rdy_b) begin pb = 1'b1; mba = ba; mbd = bd; end
            else if (wb) pb = 1'b0;
        end
        if (m_known) begin
            chk("reg_we", reg_we, ewe);
            chk("reg_waddr", reg_waddr, ewa);
            chk("reg_wdata", reg_wdata, ewd);
            chk("busy", busy, pa || pb || ewe);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    int                a_sent, a_got, b_at;
    logic              we_log [4];
    logic [ADDR_W-1:0] wa_log [4];
    logic [DATA_W-1:0] wd_log [4];

    task automatic observe_cont(input int t);
        if (reg_we && reg_waddr == 5'd1) begin
            chk("cont_a_order", reg_wdata, a_got);
            a_got++;
        end
        if (reg_we && reg_waddr == 5'd9) begin
            chk("cont_b_data", reg_wdata, 32'hABCD);
            b_at = t;
        end
    endtask

    initial begin
        // Reset held for two edges with A requesting.
        step(1'b0, 1'b1, 5'd2, 32'h99, 1'b0, '0, '0);
        step(1'b0, 1'b1, 5'd2, 32'h99, 1'b0, '0, '0);
        chk("rst_we", reg_we, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_busy", busy, 0);
        step(1'b1, 1'b1, 5'd2, 32'h99, 1'b0, '0, '0);
        chk("first_we_early", reg_we, 0);
        idle(1);
        chk("first_we", reg_we, 1);
        chk("first_waddr", reg_waddr, 2);
        chk("first_wdata", reg_wdata, 32'h99);
        idle(2);

        // Port A stream 5,6,7.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(1'b1, 1'b1, 5'(5 + i), 32'h11 * (i + 1), 1'b0, '0, '0);
            else       idle(1);
            if (i < 3) chk("streamA_ready", a_ready, 1);
            we_log[i] = reg_we; wa_log[i] = reg_waddr; wd_log[i] = reg_wdata;
        end
        for (int i = 1; i < 4; i++) begin
            chk("streamA_we", we_log[i], 1);
            chk("streamA_waddr", wa_log[i], 5 + i - 1);
            chk("streamA_wdata", wd_log[i], 32'h11 * i);
        end
        idle(2);

        // Write to x0 is swallowed.
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'hDEADBEEF);
        chk("x0_busy_loaded", busy, 1);
        idle(1);
        chk("x0_we0", reg_we, 0);
        idle(1);
        chk("x0_we1", reg_we, 0);
        chk("x0_busy", busy, 0);

        // Contention: A every cycle, B must win after MAX_WAIT losses.
        a_sent = 0; a_got = 0; b_at = -1;
        for (int t = 0; t < 14; t++) begin
            step(1'b1, 1'b1, 5'd1, a_sent, t == 0, 5'd9, 32'hABCD);
            if (m_rdy_a) a_sent++;
            observe_cont(t);
        end
        for (int t = 14; t < 17; t++) begin
            idle(1);
            observe_cont(t);
        end
        chk("cont_b_at", b_at, MAX_WAIT + 1);
        chk("cont_a_count", a_got, a_sent);
        idle(1);

        // Simultaneous first requests: A then B.
        step(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        idle(1);
        chk("simul_first", {reg_we, reg_waddr}, {1'b1, 5'd3});
        idle(1);
        chk("simul_second", {reg_we, reg_waddr}, {1'b1, 5'd4});
        idle(2);

        // Reset with both buffers full drops both writes.
        step(1'b1, 1'b1, 5'd10, 32'h1010, 1'b1, 5'd11, 32'h1111);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("midrst_we", reg_we, 0);
        end
        chk("midrst_busy", busy, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 60) != 0,
                 $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1) != 0, 5'($urandom_range(0, 31)), $urandom);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
